if_id_pipe_stage: RTL

- Parametrised IF/ID pipeline stage; successor to the fixed 16-bit/3-bit fetch-decode register.
- Carries instruction and PC from fetch to decode.
- Adds valid/ready handshaking, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush for branch redirects, and a saturating stall-cycle counter for performance debug.

---
 rtl/if_id_pipe_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module if_id_pipe_stage #(
  parameter int                     INSTR_WIDTH     = 16,
  parameter int                     PC_WIDTH        = 3,
  parameter bit                     SKID_ENABLE     = 1'b1,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR       = '0,
  parameter int                     STALL_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     instruction_in,
  input  logic [PC_WIDTH-1:0]        pc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     instruction_out,
  output logic [PC_WIDTH-1:0]        pc_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t                 state;
  logic                   in_ready_r;
  logic [INSTR_WIDTH-1:0] main_instr, skid_instr;
  logic [PC_WIDTH-1:0]    main_pc, skid_pc;
  logic                   in_xfer, out_xfer;

  assign out_valid = (state != EMPTY);
  assign in_ready  = SKID_ENABLE ? in_ready_r : (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    instruction_out = NOP_INSTR;
    pc_out          = '0;
    if (out_valid) begin
      instruction_out = main_instr;
      pc_out          = main_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      main_instr  <= '0;
      main_pc     <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_WIDTH'(1);

      // Flush wins over any coincident transfer; in_ready stays open so fetch is not stalled.
      if (flush) begin
        state      <= EMPTY;
        in_ready_r <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (in_xfer) begin
              main_instr <= instruction_in;
              main_pc    <= pc_in;
              state      <= FULL;
            end
          end
          FULL: begin
            if (in_xfer && out_xfer) begin
              main_instr <= instruction_in;
              main_pc    <= pc_in;
            end else if (in_xfer) begin
              if (SKID_ENABLE) begin
                skid_instr <= instruction_in;
                skid_pc    <= pc_in;
                state      <= SKID;
                in_ready_r <= 1'b0;
              end else begin
                main_instr <= instruction_in;
                main_pc    <= pc_in;
              end
            end else if (out_xfer) begin
              state <= EMPTY;
            end
          end
          SKID: begin
            if (out_xfer) begin
              main_instr <= skid_instr;
              main_pc    <= skid_pc;
              state      <= FULL;
              in_ready_r <= 1'b1;
            end
          end
          default: begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
